// File: rtl/hangman_pkg.sv
// Shared letter encoding and game state type for the hangman engine.
package hangman_pkg;

   localparam int LETTER_W = 5;

   localparam logic [LETTER_W-1:0] LETTER_A     = LETTER_W'(0);
   localparam logic [LETTER_W-1:0] LETTER_Z     = LETTER_W'(25);
   localparam logic [LETTER_W-1:0] LETTER_BLANK = LETTER_W'(31);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      CHECK = 3'd2,
      WIN   = 3'd3,
      LOSE  = 3'd4
   } state_t;

endpackage

// File: rtl/hangman_if.sv
// Player controls in, display feeds out. The master drives the controls; the engine is the slave.
interface hangman_if
   import hangman_pkg::*;
#(
   parameter int WORD_LEN   = 6,
   parameter int MAX_MISSES = 6
);
   logic                         up_down;
   logic                         step;
   logic                         confirm;
   logic                         new_game;
   logic [WORD_LEN*LETTER_W-1:0] word_in;
   logic [LETTER_W-1:0]          cur_letter;
   logic [WORD_LEN*LETTER_W-1:0] slot_letters;
   logic [WORD_LEN-1:0]          revealed;
   logic [3:0]                   misses;
   logic [MAX_MISSES-1:0]        miss_leds;
   logic                         dup;
   logic                         won;
   logic                         lost;
   logic                         playing;

   modport master (
      output up_down, step, confirm, new_game, word_in,
      input  cur_letter, slot_letters, revealed, misses, miss_leds, dup, won, lost, playing
   );

   modport slave (
      input  up_down, step, confirm, new_game, word_in,
      output cur_letter, slot_letters, revealed, misses, miss_leds, dup, won, lost, playing
   );
endinterface

// File: rtl/hangman_letter_selector.sv
// Wrapping A..Z up/down letter counter advanced by single-cycle step pulses.
module letter_selector
   import hangman_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                up_down,
   input  logic                step,
   output logic [LETTER_W-1:0] letter
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         letter <= LETTER_A;
      end else if (step) begin
         if (up_down)
            letter <= (letter == LETTER_Z) ? LETTER_A : letter + 1'b1;
         else
            letter <= (letter == LETTER_A) ? LETTER_Z : letter - 1'b1;
      end
   end

endmodule

// File: rtl/hangman_engine.sv
// Hangman game core: latched word, reveal mask, guess history, miss count and win/lose FSM.
//  state | meaning
//  IDLE  | after reset, waiting for new_game
//  PLAY  | waiting for a confirm rising edge
//  CHECK | one cycle scoring guess_q against the word and history
//  WIN   | every slot revealed; holds until new_game
//  LOSE  | miss budget spent, whole word shown; holds until new_game
module hangman_engine
   import hangman_pkg::*;
#(
   parameter int WORD_LEN   = 6,
   parameter int MAX_MISSES = 6
)(
   input  logic     clk,
   input  logic     rst,
   hangman_if.slave bus
);

   localparam logic [3:0] MAX_M4 = 4'(MAX_MISSES);

   state_t                       state_q, state_n;
   logic [WORD_LEN*LETTER_W-1:0] word_q, word_n;
   logic [WORD_LEN-1:0]          rev_q, rev_n;
   logic [25:0]                  guessed_q, guessed_n;
   logic [3:0]                   misses_q, misses_n;
   logic                         dup_q, dup_n;
   logic [LETTER_W-1:0]          guess_q, guess_n;
   logic                         conf_d;
   logic                         conf_rise;
   logic [LETTER_W-1:0]          letter;
   logic [WORD_LEN-1:0]          match;
   logic [WORD_LEN-1:0]          blank;
   logic [MAX_MISSES-1:0]        leds;

   letter_selector u_sel (
      .clk     (clk),
      .rst     (rst),
      .up_down (bus.up_down),
      .step    (bus.step),
      .letter  (letter)
   );

   assign conf_rise = bus.confirm & ~conf_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         word_q    <= {WORD_LEN{LETTER_BLANK}};
         rev_q     <= '0;
         guessed_q <= '0;
         misses_q  <= '0;
         dup_q     <= 1'b0;
         guess_q   <= '0;
         conf_d    <= 1'b0;
      end else begin
         state_q   <= state_n;
         word_q    <= word_n;
         rev_q     <= rev_n;
         guessed_q <= guessed_n;
         misses_q  <= misses_n;
         dup_q     <= dup_n;
         guess_q   <= guess_n;
         conf_d    <= bus.confirm;
      end
   end

   always_comb begin
      state_n   = state_q;
      word_n    = word_q;
      rev_n     = rev_q;
      guessed_n = guessed_q;
      misses_n  = misses_q;
      dup_n     = 1'b0;
      guess_n   = guess_q;
      match     = '0;
      blank     = '0;
      for (int i = 0; i < WORD_LEN; i++) begin
         blank[i] = (bus.word_in[i*LETTER_W +: LETTER_W] == LETTER_BLANK);
         match[i] = (word_q[i*LETTER_W +: LETTER_W] == guess_q);
      end

      // new_game overrides any pending guess, including one being scored in CHECK
      if (bus.new_game) begin
         word_n    = bus.word_in;
         rev_n     = blank;
         guessed_n = '0;
         misses_n  = '0;
         state_n   = (&blank) ? WIN : PLAY;
      end else begin
         case (state_q)
            PLAY: begin
               if (conf_rise) begin
                  guess_n = letter;
                  state_n = CHECK;
               end
            end
            CHECK: begin
               if (guessed_q[guess_q]) begin
                  dup_n   = 1'b1;
                  state_n = PLAY;
               end else begin
                  guessed_n[guess_q] = 1'b1;
                  if (|match)
                     rev_n = rev_q | match;
                  else if (misses_q < MAX_M4)
                     misses_n = misses_q + 4'd1;
                  if (&rev_n) begin
                     state_n = WIN;
                  end else if (misses_n == MAX_M4) begin
                     state_n = LOSE;
                     rev_n   = '1;
                  end else begin
                     state_n = PLAY;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      leds = '0;
      for (int k = 0; k < MAX_MISSES; k++)
         leds[k] = (misses_q > 4'(k));
   end

   assign bus.cur_letter   = letter;
   assign bus.slot_letters = word_q;
   assign bus.revealed     = rev_q;
   assign bus.misses       = misses_q;
   assign bus.miss_leds    = leds;
   assign bus.dup          = dup_q;
   assign bus.won          = (state_q == WIN);
   assign bus.lost         = (state_q == LOSE);
   assign bus.playing      = (state_q == PLAY) || (state_q == CHECK);

endmodule

// File: tb/tb_hangman_engine.sv
// Directed scenario bench for hangman_engine with hand-computed expectations.
module tb_hangman_engine;
   import hangman_pkg::*;

   localparam int WL = 6;
   localparam int MM = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [4:0] sel = 5'd0;

   hangman_if #(.WORD_LEN(WL), .MAX_MISSES(MM)) bus ();

   hangman_engine #(.WORD_LEN(WL), .MAX_MISSES(MM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam logic [29:0] W_HANGMN = {5'd13, 5'd12, 5'd6, 5'd13, 5'd0, 5'd7};
   localparam logic [29:0] W_CAT    = {5'd31, 5'd31, 5'd31, 5'd19, 5'd0, 5'd2};
   localparam logic [29:0] W_BLANK  = {6{5'd31}};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_letter(input logic [4:0] target);
      for (int n = 0; n < 26 && sel != target; n++) begin
         bus.up_down = 1'b1;
         bus.step    = 1'b1;
         tick();
         bus.step = 1'b0;
         sel = (sel == 5'd25) ? 5'd0 : sel + 5'd1;
      end
   endtask

   task automatic new_game(input logic [29:0] w);
      bus.word_in  = w;
      bus.new_game = 1'b1;
      tick();
      bus.new_game = 1'b0;
   endtask

   // leaves confirm high, sampled just after the edge that ends CHECK
   task automatic press_start(input logic [4:0] l);
      goto_letter(l);
      bus.confirm = 1'b1;
      tick();
      tick();
   endtask

   task automatic release_btn();
      bus.confirm = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      vectors++;
      if ({bus.revealed, bus.misses, bus.miss_leds, bus.dup, bus.won, bus.lost, bus.playing, bus.cur_letter} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rev=%b mis=%0d leds=%b dup=%b w=%b l=%b p=%b cur=%0d expected all zero",
                  bus.revealed, bus.misses, bus.miss_leds, bus.dup, bus.won, bus.lost, bus.playing, bus.cur_letter);
      end
      vectors++;
      if (bus.slot_letters !== W_BLANK) begin
         miscompares++;
         $display("FAIL reset_word: got %h expected %h", bus.slot_letters, W_BLANK);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if (bus.playing !== 1'b0 || bus.won !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got playing=%b won=%b expected 0 0", bus.playing, bus.won);
      end
   endtask

   task automatic test_idle_ignores_confirm();
      press_start(5'd7);
      vectors++;
      if (bus.playing !== 1'b0 || bus.revealed !== 6'b0) begin
         miscompares++;
         $display("FAIL idle_confirm: got playing=%b rev=%b expected 0 000000", bus.playing, bus.revealed);
      end
      release_btn();
   endtask

   task automatic test_hit_and_dup();
      new_game(W_HANGMN);
      vectors++;
      if (bus.playing !== 1'b1 || bus.revealed !== 6'b000000 || bus.misses !== 4'd0) begin
         miscompares++;
         $display("FAIL newgame_hangmn: got playing=%b rev=%b mis=%0d expected 1 000000 0",
                  bus.playing, bus.revealed, bus.misses);
      end
      vectors++;
      if (bus.slot_letters !== W_HANGMN) begin
         miscompares++;
         $display("FAIL slot_letters: got %h expected %h", bus.slot_letters, W_HANGMN);
      end
      press_start(5'd13);
      vectors++;
      if (bus.revealed !== 6'b100100 || bus.misses !== 4'd0 || bus.dup !== 1'b0) begin
         miscompares++;
         $display("FAIL hit_n: got rev=%b mis=%0d dup=%b expected 100100 0 0", bus.revealed, bus.misses, bus.dup);
      end
      release_btn();
      press_start(5'd13);
      vectors++;
      if (bus.dup !== 1'b1 || bus.revealed !== 6'b100100 || bus.misses !== 4'd0) begin
         miscompares++;
         $display("FAIL dup_n: got dup=%b rev=%b mis=%0d expected 1 100100 0", bus.dup, bus.revealed, bus.misses);
      end
      release_btn();
      vectors++;
      if (bus.dup !== 1'b0 || bus.playing !== 1'b1) begin
         miscompares++;
         $display("FAIL dup_pulse: got dup=%b playing=%b expected 0 1", bus.dup, bus.playing);
      end
   endtask

   task automatic test_misses_to_lose();
      logic [4:0] wrong [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8};
      for (int k = 0; k < 6; k++) begin
         press_start(wrong[k]);
         if (k == 0) begin
            repeat (3) tick();
         end
         vectors++;
         if (bus.misses !== 4'(k + 1) || bus.miss_leds !== 6'((1 << (k + 1)) - 1)) begin
            miscompares++;
            $display("FAIL miss_step%0d: got mis=%0d leds=%b expected %0d %b",
                     k + 1, bus.misses, bus.miss_leds, k + 1, 6'((1 << (k + 1)) - 1));
         end
         release_btn();
      end
      vectors++;
      if (bus.lost !== 1'b1 || bus.revealed !== 6'b111111 || bus.playing !== 1'b0 || bus.won !== 1'b0) begin
         miscompares++;
         $display("FAIL lose_state: got lost=%b rev=%b playing=%b won=%b expected 1 111111 0 0",
                  bus.lost, bus.revealed, bus.playing, bus.won);
      end
      press_start(5'd9);
      release_btn();
      vectors++;
      if (bus.lost !== 1'b1 || bus.misses !== 4'd6 || bus.dup !== 1'b0) begin
         miscompares++;
         $display("FAIL lose_terminal: got lost=%b mis=%0d dup=%b expected 1 6 0", bus.lost, bus.misses, bus.dup);
      end
   endtask

   task automatic test_win_with_blanks();
      logic [4:0] g [3]   = '{5'd2, 5'd0, 5'd19};
      logic [5:0] exp [3] = '{6'b111001, 6'b111011, 6'b111111};
      new_game(W_CAT);
      vectors++;
      if (bus.revealed !== 6'b111000 || bus.misses !== 4'd0 || bus.lost !== 1'b0 || bus.playing !== 1'b1) begin
         miscompares++;
         $display("FAIL newgame_cat: got rev=%b mis=%0d lost=%b playing=%b expected 111000 0 0 1",
                  bus.revealed, bus.misses, bus.lost, bus.playing);
      end
      for (int k = 0; k < 3; k++) begin
         press_start(g[k]);
         vectors++;
         if (bus.revealed !== exp[k]) begin
            miscompares++;
            $display("FAIL cat_guess%0d: got rev=%b expected %b", k, bus.revealed, exp[k]);
         end
         release_btn();
      end
      vectors++;
      if (bus.won !== 1'b1 || bus.misses !== 4'd0 || bus.playing !== 1'b0) begin
         miscompares++;
         $display("FAIL cat_win: got won=%b mis=%0d playing=%b expected 1 0 0", bus.won, bus.misses, bus.playing);
      end
      new_game(W_BLANK);
      vectors++;
      if (bus.won !== 1'b1 || bus.revealed !== 6'b111111 || bus.playing !== 1'b0) begin
         miscompares++;
         $display("FAIL all_blank_win: got won=%b rev=%b playing=%b expected 1 111111 0",
                  bus.won, bus.revealed, bus.playing);
      end
   endtask

   task automatic test_selector_wrap();
      goto_letter(5'd0);
      vectors++;
      if (bus.cur_letter !== 5'd0) begin
         miscompares++;
         $display("FAIL sel_at_a: got %0d expected 0", bus.cur_letter);
      end
      bus.up_down = 1'b0;
      bus.step    = 1'b1;
      tick();
      bus.step = 1'b0;
      vectors++;
      if (bus.cur_letter !== 5'd25) begin
         miscompares++;
         $display("FAIL sel_wrap_down: got %0d expected 25", bus.cur_letter);
      end
      bus.up_down = 1'b1;
      bus.step    = 1'b1;
      tick();
      bus.step = 1'b0;
      vectors++;
      if (bus.cur_letter !== 5'd0) begin
         miscompares++;
         $display("FAIL sel_wrap_up: got %0d expected 0", bus.cur_letter);
      end
      sel = 5'd0;
   endtask

   task automatic test_newgame_collision();
      new_game(W_HANGMN);
      goto_letter(5'd1);
      bus.word_in  = W_HANGMN;
      bus.new_game = 1'b1;
      bus.confirm  = 1'b1;
      tick();
      bus.new_game = 1'b0;
      tick();
      vectors++;
      if (bus.misses !== 4'd0 || bus.playing !== 1'b1 || bus.revealed !== 6'b0) begin
         miscompares++;
         $display("FAIL collision_discard: got mis=%0d playing=%b rev=%b expected 0 1 000000",
                  bus.misses, bus.playing, bus.revealed);
      end
      release_btn();
      press_start(5'd1);
      vectors++;
      if (bus.misses !== 4'd1 || bus.dup !== 1'b0) begin
         miscompares++;
         $display("FAIL collision_mask_clear: got mis=%0d dup=%b expected 1 0", bus.misses, bus.dup);
      end
      release_btn();
   endtask

   task automatic test_reset_mid_check();
      goto_letter(5'd7);
      bus.confirm = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({bus.revealed, bus.misses, bus.miss_leds, bus.dup, bus.won, bus.lost, bus.playing, bus.cur_letter} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_check: got rev=%b mis=%0d leds=%b dup=%b w=%b l=%b p=%b cur=%0d expected all zero",
                  bus.revealed, bus.misses, bus.miss_leds, bus.dup, bus.won, bus.lost, bus.playing, bus.cur_letter);
      end
      bus.confirm = 1'b0;
      sel = 5'd0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bus.up_down  = 1'b1;
      bus.step     = 1'b0;
      bus.confirm  = 1'b0;
      bus.new_game = 1'b0;
      bus.word_in  = '0;
      test_reset();
      test_idle_ignores_confirm();
      test_hit_and_dup();
      test_misses_to_lose();
      test_win_with_blanks();
      test_selector_wrap();
      test_newgame_collision();
      test_reset_mid_check();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
